// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared defaults and functional-unit identifiers for the register file
// write-back sequencer and its hazard scoreboard.
package regfile_wb_scoreboard_pkg;

    localparam int NUM_UNITS_DEF = 4;
    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W_DEF    = 32;
    localparam int NUM_REGS      = 32;

    // Requester index of each completing functional unit on the done buses.
    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_LSU = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

endpackage

// File: rtl/regfile_wb_scoreboard_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over a request vector, search starting
// at an internal pointer that moves past the winner after every grant.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic             any_o,
    output logic [PTR_W-1:0] win_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic             found;

    // Pick the first requester at or after the pointer; nothing wins in reset.
    always_comb begin
        grant_o = '0;
        win_o   = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % N);
            if (!found && !rst_i && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                win_o        = idx;
            end
        end
        any_o = found;
    end

    // Pointer moves to the unit after the winner; it holds when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win_o == PTR_W'(N - 1)) ? '0 : win_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register file write-port sequencer: arbitrates unit completions onto the
// single write port and tracks pending destinations to stall RAW/WAW issue.
module regfile_wb_scoreboard
    import regfile_wb_scoreboard_pkg::*;
#(
    parameter  int NUM_UNITS = NUM_UNITS_DEF,
    parameter  int ADDR_W    = ADDR_W_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    localparam int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        issue_valid,
    input  logic [UW-1:0]               issue_unit,
    input  logic [ADDR_W-1:0]           issue_rs1,
    input  logic [ADDR_W-1:0]           issue_rs2,
    input  logic [ADDR_W-1:0]           issue_rd,
    output logic                        issue_ready,
    input  logic [NUM_UNITS-1:0]        done_valid,
    input  logic [NUM_UNITS*ADDR_W-1:0] done_addr,
    input  logic [NUM_UNITS*DATA_W-1:0] done_data,
    output logic [NUM_UNITS-1:0]        done_grant,
    output logic                        shouldWrite,
    output logic [ADDR_W-1:0]           writeAddress,
    output logic [DATA_W-1:0]           writeData,
    output logic [NUM_REGS-1:0]         busy_vector
);

    logic [ADDR_W-1:0]   u_addr [NUM_UNITS];
    logic [DATA_W-1:0]   u_data [NUM_UNITS];
    logic                grant_any;
    logic [UW-1:0]       win_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] eff_busy;
    logic                issue_fire;

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
        assign u_addr[k] = done_addr[k*ADDR_W +: ADDR_W];
        assign u_data[k] = done_data[k*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N (NUM_UNITS)
    ) u_arb (
        .clk_i   (clock),
        .rst_i   (reset),
        .req_i   (done_valid),
        .grant_o (done_grant),
        .any_o   (grant_any),
        .win_o   (win_idx)
    );

    // Steer the winning unit onto the write port; an x0 completion is
    // consumed without enabling the write.
    always_comb begin
        sel_addr     = u_addr[win_idx];
        sel_data     = u_data[win_idx];
        shouldWrite  = grant_any && (sel_addr != '0);
        writeAddress = shouldWrite ? sel_addr : '0;
        writeData    = grant_any ? sel_data : '0;
    end

    // A register being written this cycle is treated as free (write-through).
    always_comb begin
        clr_mask    = shouldWrite ? (NUM_REGS'(1) << writeAddress) : '0;
        eff_busy    = busy_q & ~clr_mask;
        issue_ready = ~reset & ~eff_busy[issue_rs1] & ~eff_busy[issue_rs2]
                             & ~eff_busy[issue_rd];
        issue_fire  = issue_valid & issue_ready;
    end

    // Scoreboard next state: clear on write-back, then set on issue so a
    // same-cycle set of the same register wins; x0 never becomes busy.
    always_comb begin
        busy_d = busy_q;
        if (shouldWrite) begin
            busy_d[writeAddress] = 1'b0;
        end
        if (issue_fire && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vector = busy_q;

`ifndef SYNTHESIS
    // Simulation-only record of which unit owes each pending write.
    logic [UW-1:0] owner_q [NUM_REGS];

    // Capture the producing unit whenever a real destination issues.
    always_ff @(posedge clock) begin
        if (issue_fire && (issue_rd != '0)) begin
            owner_q[issue_rd] <= issue_unit;
        end
    end

    a_completion_expected : assert property (
        @(posedge clock) disable iff (reset)
        shouldWrite |-> (busy_q[writeAddress] && (owner_q[writeAddress] == win_idx))
    );
`endif

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Scoreboard bench for regfile_wb_scoreboard: directed scenarios followed by
// randomized issue/completion traffic against a behavioural model.
module tb_regfile_wb_scoreboard;
    import regfile_wb_scoreboard_pkg::*;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [1:0]      issue_unit;
    logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd;
    logic            issue_ready;
    logic [N-1:0]    done_valid;
    logic [N*AW-1:0] done_addr;
    logic [N*DW-1:0] done_data;
    logic [N-1:0]    done_grant;
    logic            shouldWrite;
    logic [AW-1:0]   writeAddress;
    logic [DW-1:0]   writeData;
    logic [31:0]     busy_vector;

    logic [N-1:0]    u_valid;
    logic [AW-1:0]   u_addr [N];
    logic [DW-1:0]   u_data [N];

    regfile_wb_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_unit   (issue_unit),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .done_valid   (done_valid),
        .done_addr    (done_addr),
        .done_data    (done_data),
        .done_grant   (done_grant),
        .shouldWrite  (shouldWrite),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .busy_vector  (busy_vector)
    );

    initial forever #5 clock = ~clock;

    assign done_valid = u_valid;
    always_comb begin
        done_addr = '0;
        done_data = '0;
        for (int k = 0; k < N; k++) begin
            done_addr[k*AW +: AW] = u_addr[k];
            done_data[k*DW +: DW] = u_data[k];
        end
    end

    typedef struct {
        bit [31:0]   busy;
        bit          ready;
        bit [N-1:0]  grant;
        bit          sw;
        bit [AW-1:0] wa;
        bit [DW-1:0] wd;
    } exp_t;

    exp_t      exp_q[$];
    int        checks = 0;
    int        errors = 0;

    // Reference model: set of pending destinations, round-robin start unit,
    // and per-unit ordered lists of destinations still owed.
    bit [31:0] m_busy;
    int        m_ptr;
    int        m_win;
    bit        m_fire;
    int        u_q [N][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit m_eff_busy(input int r, input bit sw, input int wa);
        return (r != 0) && m_busy[r] && !(sw && (wa == r));
    endfunction

    // Predict this cycle's outputs, queue them, advance the model, take the edge.
    task automatic tick();
        exp_t e;
        int   k;
        bit   sw;
        int   wa;
        m_win = -1;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (m_win < 0 && u_valid[k]) m_win = k;
            end
        end
        e.grant = '0;
        if (m_win >= 0) e.grant[m_win] = 1'b1;
        sw      = (m_win >= 0) && (u_addr[m_win] != 0);
        wa      = sw ? int'(u_addr[m_win]) : 0;
        e.sw    = sw;
        e.wa    = AW'(wa);
        e.wd    = sw ? u_data[m_win] : '0;
        e.busy  = m_busy;
        e.ready = !reset && !m_eff_busy(int'(issue_rs1), sw, wa)
                         && !m_eff_busy(int'(issue_rs2), sw, wa)
                         && !m_eff_busy(int'(issue_rd), sw, wa);
        m_fire  = issue_valid && e.ready;
        exp_q.push_back(e);
        if (reset) begin
            m_busy = '0;
            m_ptr  = 0;
        end else begin
            if (sw) m_busy[wa] = 1'b0;
            if (m_fire && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (m_win >= 0) m_ptr = (m_win + 1) % N;
        end
        @(posedge clock);
        #1;
        if (m_win >= 0) begin
            u_valid[m_win] = 1'b0;
            if (u_q[m_win].size() > 0) void'(u_q[m_win].pop_front());
        end
        if (m_fire) u_q[issue_unit].push_back(int'(issue_rd));
    endtask

    task automatic iss(input bit v, input int unit, input int rs1, input int rs2, input int rd);
        issue_valid = v;
        issue_unit  = 2'(unit);
        issue_rs1   = AW'(rs1);
        issue_rs2   = AW'(rs2);
        issue_rd    = AW'(rd);
    endtask

    task automatic req(input int k, input int addr, input logic [DW-1:0] data);
        u_valid[k] = 1'b1;
        u_addr[k]  = AW'(addr);
        u_data[k]  = data;
    endtask

    task automatic clear_units();
        u_valid = '0;
        for (int k = 0; k < N; k++) begin
            u_addr[k] = '0;
            u_data[k] = '0;
            u_q[k].delete();
        end
    endtask

    function automatic int pick_reg();
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue_ready", issue_ready, e.ready);
                chk("done_grant", done_grant, e.grant);
                chk("shouldWrite", shouldWrite, e.sw);
                chk("writeAddress", writeAddress, e.wa);
                if (e.sw) chk("writeData", writeData, e.wd);
                chk("busy_vector", busy_vector, e.busy);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        m_busy = '0;
        m_ptr  = 0;
        reset  = 1'b1;
        iss(0, 0, 0, 0, 0);
        clear_units();
        @(posedge clock);
        #1;

        // Reset held with every unit requesting.
        for (int k = 0; k < N; k++) req(k, 0, '0);
        tick();
        tick();
        reset = 1'b0;
        clear_units();
        tick();

        // Round-robin: destinations 10/11/12 pending on units 0/1/3.
        iss(1, int'(UNIT_ALU), 0, 0, 10); tick();
        iss(1, int'(UNIT_LSU), 0, 0, 11); tick();
        iss(1, int'(UNIT_DIV), 0, 0, 12); tick();
        iss(0, 0, 0, 0, 0);
        req(0, 10, 32'h0000_00A0); req(1, 11, 32'h0000_00B1); req(3, 12, 32'h0000_00C3);
        tick();
        req(0, 0, '0); tick();
        req(1, 0, '0); tick();
        req(3, 0, '0); tick();
        tick();
        tick();

        // RAW stall on x5 until unit MUL completes it.
        iss(1, int'(UNIT_MUL), 0, 0, 5); tick();
        iss(1, int'(UNIT_ALU), 5, 0, 0); tick();
        tick();
        req(int'(UNIT_MUL), 5, 32'hDEAD_BEEF); tick();
        iss(0, 0, 0, 0, 0); tick();
        req(0, 0, '0); tick();

        // WAW stall on x7, then an x0 destination and its completion.
        iss(1, int'(UNIT_LSU), 0, 0, 7); tick();
        iss(1, int'(UNIT_MUL), 0, 0, 7); tick();
        tick();
        iss(1, int'(UNIT_DIV), 0, 0, 0); tick();
        iss(0, 0, 0, 0, 0);
        req(3, 0, '0); tick();
        req(1, 7, 32'h1234_5678); tick();

        // Grant clears x3 in the same cycle a new x3 writer issues.
        iss(1, int'(UNIT_ALU), 0, 0, 3); tick();
        req(0, 3, 32'h0BAD_F00D);
        iss(1, int'(UNIT_MUL), 0, 0, 3); tick();
        iss(0, 0, 0, 0, 0); tick();
        req(2, 3, 32'h3333_3333); tick();
        tick();

        // Reset in the middle of traffic.
        iss(1, 0, 0, 0, 4); tick();
        iss(1, 1, 0, 0, 5); tick();
        iss(1, 2, 0, 0, 6); tick();
        iss(1, 3, 0, 0, 7); tick();
        iss(0, 0, 0, 0, 0);
        req(1, 5, 32'h5555_AAAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_units();
        tick();
        for (int k = 0; k < N; k++) req(k, 0, '0);
        for (int n = 0; n < N; n++) tick();
        clear_units();

        // Randomized traffic obeying the unit protocol.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!u_valid[k] && u_q[k].size() > 0 && $urandom_range(0, 2) == 0) begin
                    req(k, u_q[k][0], $urandom);
                end
            end
            iss(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                pick_reg(), pick_reg(), pick_reg());
            reset = ($urandom_range(0, 299) == 0);
            tick();
            if (reset) clear_units();
            reset = 1'b0;
        end

        iss(0, 0, 0, 0, 0);
        clear_units();
        tick();
        tick();
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
